// File: rtl/i2s_pkg.sv
// Shared types and slot constants for the I2S transmit serializer.
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN
    } state_t;

    localparam int WORD_W     = 16;
    localparam int SLOT_LEFT  = 0;
    localparam int SLOT_RIGHT = 16;
    localparam int SLOT_LAST  = 31;

    // Word select is high from one slot before the right MSB up to the slot before the left MSB.
    function automatic logic lr_of_slot(input logic [4:0] s);
        return (s >= 5'd15) && (s <= 5'd30);
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit clock divider: toggles bclk every CLK_DIV clk while run is high, flags each 1->0 toggle.
module i2s_bclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bclk,
    output logic fall_event
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] div_cnt;
    logic          tc;

    assign tc         = run && (div_cnt == CW'(CLK_DIV - 1));
    assign fall_event = tc && bclk;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: prefetches alternating left/right words from an upstream buffer and
// shifts them out MSB-first, one BCLK after each word-select edge.
module i2s_tx_serializer import i2s_pkg::*; #(
    parameter int CLK_DIV    = 4,
    parameter int READY_W    = 2,
    parameter int FETCH_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              word_avail,
    input  logic [WORD_W-1:0] data_in,
    output logic              ready,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              underrun,
    output logic              busy
);

    localparam int FCW = $clog2(FETCH_WAIT + 1);

    state_t            state;
    logic [4:0]        slot, slot_nxt;
    logic [WORD_W-1:0] shift_reg, next_word;
    logic              next_valid, fetch_pend, fetch_busy, ready_q;
    logic [FCW-1:0]    fcnt;
    logic              fall_event, wrap, stop, load, fetch_start;

    i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
        .clk        (clk),
        .rst        (rst),
        .run        (state == ST_RUN),
        .bclk       (bclk),
        .fall_event (fall_event)
    );

    assign wrap     = (slot == 5'(SLOT_LAST));
    assign slot_nxt = wrap ? 5'(SLOT_LEFT) : slot + 5'd1;
    assign stop     = fall_event && wrap && !enable;
    assign load     = fall_event && !stop &&
                      (slot_nxt == 5'(SLOT_LEFT) || slot_nxt == 5'(SLOT_RIGHT));
    assign fetch_start = (state == ST_PRIME && !next_valid && !fetch_busy) ||
                         (state == ST_RUN && fetch_pend);

    // A reset must silence the fetch strobe immediately, not one clock later.
    assign ready = ready_q && !rst;
    assign busy  = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            slot       <= 5'(SLOT_LAST);
            shift_reg  <= '0;
            next_word  <= '0;
            next_valid <= 1'b0;
            fetch_pend <= 1'b0;
            fetch_busy <= 1'b0;
            ready_q    <= 1'b0;
            fcnt       <= '0;
            lrclk      <= 1'b0;
            sdata      <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (fetch_start) begin
                fetch_pend <= 1'b0;
                if (word_avail) begin
                    ready_q    <= 1'b1;
                    fetch_busy <= 1'b1;
                    fcnt       <= FCW'(1);
                end else begin
                    next_word  <= '0;
                    next_valid <= 1'b1;
                    underrun   <= 1'b1;
                end
            end else if (fetch_busy) begin
                ready_q <= (fcnt < FCW'(READY_W));
                if (fcnt == FCW'(FETCH_WAIT)) begin
                    next_word  <= data_in;
                    next_valid <= 1'b1;
                    fetch_busy <= 1'b0;
                end else begin
                    fcnt <= fcnt + FCW'(1);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        underrun <= 1'b0;
                        state    <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    if (next_valid) begin
                        if (enable) begin
                            state     <= ST_RUN;
                            slot      <= 5'(SLOT_LAST);
                            shift_reg <= '0;
                            sdata     <= 1'b0;
                            lrclk     <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        // The word prefetched during the right channel stays for the next start.
                        state     <= ST_IDLE;
                        slot      <= 5'(SLOT_LAST);
                        shift_reg <= '0;
                        sdata     <= 1'b0;
                        lrclk     <= 1'b0;
                    end else if (fall_event) begin
                        slot  <= slot_nxt;
                        lrclk <= lr_of_slot(slot_nxt);
                        if (load) begin
                            shift_reg  <= next_word;
                            sdata      <= next_word[WORD_W-1];
                            next_valid <= 1'b0;
                            fetch_pend <= 1'b1;
                        end else begin
                            shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
                            sdata     <= shift_reg[WORD_W-2];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The previous fetch must have fully landed before a channel boundary consumes it.
    always_ff @(posedge clk) begin
        if (!rst && load)
            assert (next_valid && !fetch_busy && !fetch_pend);
    end

endmodule
